tl_edge_arbiter_2to1: RTL and testbench
=======================================

Name: tl_edge_arbiter_2to1

Overview:
- Merges the two TL-UL edge-buffer output ports (auto_out_0 / auto_out_1 of the edge buffer stage) into one master port toward the L3 edge.
- A channel: round-robin arbitration, with multi-beat lock and grant stickiness.
- D channel: responses are routed back by the source ID prefix.
- Out-port source IDs are widened by 1 bit; the MSB carries the input port index.

Parameters:
- DATA_BITS, 256, A/D data width; beat = DATA_BITS/8 bytes.
- LOG_BEAT, 5, log2(bytes per beat).
- SRC_BITS, 7, input source width; the output source width is SRC_BITS+1.
- ADDR_BITS, 36, address width.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- auto_in_N_a_ready  out  1  (N=0,1) A accept to input port N
- auto_in_N_a_valid  in  1  A request valid
- auto_in_N_a_bits_opcode  in  3  TL opcode
- auto_in_N_a_bits_size  in  3  log2 bytes
- auto_in_N_a_bits_source  in  SRC_BITS  source ID
- auto_in_N_a_bits_address  in  ADDR_BITS  address
- auto_in_N_a_bits_mask  in  DATA_BITS/8  byte mask
- auto_in_N_a_bits_data  in  DATA_BITS  data
- auto_in_N_d_ready  in  1  D accept from port N
- auto_in_N_d_valid, _opcode(3), _param(2), _size(3), _source(SRC_BITS), _denied(1), _data(DATA_BITS)  out  D response to port N
- auto_out_a_ready  in  1  downstream A accept
- auto_out_a_valid, _opcode, _size, _address, _mask, _data  out  merged A request
- auto_out_a_bits_source  out  SRC_BITS+1  {port index, in source}
- auto_out_d_ready  out  1  D accept
- auto_out_d_valid, _opcode, _param, _size, _denied, _data  in  D response
- auto_out_d_bits_source  in  SRC_BITS+1  routed by MSB

Behaviour:
- Beat count: beats(size) = size>LOG_BEAT ? 1<<(size-LOG_BEAT) : 1. This gives 1..4 beats for size ≤ 7.
- A multi-beat only for opcode 0 (PutFullData) and 1 (PutPartialData). D multi-beat only for opcode 1 (AccessAckData).

A-channel state:
- State is IDLE / BUSY, plus:
  - grant reg (1b);
  - rr_ptr (1b, port given priority next);
  - a_cnt (2b, beats remaining − 1).
- Reset values: IDLE, rr_ptr=0, a_cnt=0, grant=0.

IDLE:
- sel = rr_ptr if auto_in_{rr_ptr}_a_valid, else the other port if its valid is high.
- out_a_valid = OR of the input valids. Bits come from sel combinationally (zero-cycle latency). Source = {sel, in source}.
- auto_in_sel_a_ready = auto_out_a_ready. The non-selected ready = 0.
- On fire of a single-beat message:
  - stay IDLE;
  - rr_ptr ← ~sel.
- On fire of a multi-beat first beat:
  - go BUSY;
  - grant ← sel;
  - a_cnt ← beats−2.
- Valid high with ready low:
  - go BUSY;
  - grant ← sel;
  - a_cnt ← beats−1.
  - Purpose: the grant must not change while out valid is pending (TL stability rule).

BUSY:
- The only path is the grant port.
- Each fire with a_cnt≠0 decrements a_cnt.
- A fire with a_cnt=0 is the last beat:
  - go IDLE;
  - rr_ptr ← ~grant.
- The other port's ready is held 0 throughout.

D-channel state:
- dst = auto_out_d_bits_source[SRC_BITS]. Destination port N gets valid and bits with the MSB stripped. auto_out_d_ready = auto_in_dst_d_ready.
- The non-destination port's d_valid = 0.
- d_cnt (2b, reset 0) tracks a multi-beat AccessAckData. It loads beats−2 on the first fire when beats>1 and decrements on each later fire.
- D routing is stateless per beat. The counter drives the assertion that dst is constant within a burst (simulation-only check).
- The A and D channels are fully independent. Simultaneous A and D fires are permitted every cycle.

Resets and outputs:
- Reset asserted mid-burst: the next edge forces IDLE, with a_cnt=d_cnt=0 and rr_ptr=0.
- Ready and valid outputs are combinational and carry no reset-specific value. During reset, all auto_in_N_a_ready = 0.

Test Plan:
- Both ports issue single-beat Get (opcode 4, size 5) continuously, out ready=1 → grants alternate 0,1,0,1; out source MSB matches; throughput 1/cycle.
- Port0 PutFullData size 7 (4 beats) with port1 Get pending → four consecutive port0 beats, port1 ready=0 throughout; port1 granted on cycle 5.
- Port1 valid, out ready=0 for 3 cycles, port0 asserts valid in cycle 2 → out bits stay port1 until fire; port0 served next.
- D AccessAckData size 6 (2 beats) with source 0x85 → port1 d_valid both beats, source 0x05; port0 d_valid=0; back-pressure via in_1_d_ready stalls out_d_ready.
- Reset pulsed after beat 2 of a 4-beat Put → next cycle IDLE, rr_ptr=0; a new port0 single-beat Get passes immediately.
- Simultaneous A fire and D fire on opposite ports for 100 random cycles → no lost or duplicated beats (scoreboard count match).

Source files
------------

// File: rtl/tl_edge_arbiter_2to1.sv
// tl_edge_arbiter_2to1
//
// Merges the two TL-UL edge-buffer output ports onto one master port toward
// the L3 edge.
//   A channel: round-robin arbitration between the two input ports.
//              Multi-beat Put bursts are locked to one port. A request that is
//              presented but stalled keeps its grant until it fires.
//   D channel: each response beat is routed to the input port named by the
//              MSB of its source ID. That MSB is stripped before the response
//              is handed on.
//   The outgoing A source ID is {input port index, input source ID}.
//
// Ports:
//   clock, reset                  sole clock; synchronous active-high reset
//   auto_in_{0,1}_a_*             A requests from the two input ports
//   auto_in_{0,1}_d_*             D responses back to the two input ports
//   auto_out_a_*                  merged A request (source is SRC_BITS+1 wide)
//   auto_out_d_*                  D response from downstream (source MSB = port)
module tl_edge_arbiter_2to1 #(
    parameter int DATA_BITS = 256,
    parameter int LOG_BEAT  = 5,
    parameter int SRC_BITS  = 7,
    parameter int ADDR_BITS = 36
) (
    input  logic                   clock,
    input  logic                   reset,

    output logic                   auto_in_0_a_ready,
    input  logic                   auto_in_0_a_valid,
    input  logic [2:0]             auto_in_0_a_bits_opcode,
    input  logic [2:0]             auto_in_0_a_bits_size,
    input  logic [SRC_BITS-1:0]    auto_in_0_a_bits_source,
    input  logic [ADDR_BITS-1:0]   auto_in_0_a_bits_address,
    input  logic [DATA_BITS/8-1:0] auto_in_0_a_bits_mask,
    input  logic [DATA_BITS-1:0]   auto_in_0_a_bits_data,
    input  logic                   auto_in_0_d_ready,
    output logic                   auto_in_0_d_valid,
    output logic [2:0]             auto_in_0_d_bits_opcode,
    output logic [1:0]             auto_in_0_d_bits_param,
    output logic [2:0]             auto_in_0_d_bits_size,
    output logic [SRC_BITS-1:0]    auto_in_0_d_bits_source,
    output logic                   auto_in_0_d_bits_denied,
    output logic [DATA_BITS-1:0]   auto_in_0_d_bits_data,

    output logic                   auto_in_1_a_ready,
    input  logic                   auto_in_1_a_valid,
    input  logic [2:0]             auto_in_1_a_bits_opcode,
    input  logic [2:0]             auto_in_1_a_bits_size,
    input  logic [SRC_BITS-1:0]    auto_in_1_a_bits_source,
    input  logic [ADDR_BITS-1:0]   auto_in_1_a_bits_address,
    input  logic [DATA_BITS/8-1:0] auto_in_1_a_bits_mask,
    input  logic [DATA_BITS-1:0]   auto_in_1_a_bits_data,
    input  logic                   auto_in_1_d_ready,
    output logic                   auto_in_1_d_valid,
    output logic [2:0]             auto_in_1_d_bits_opcode,
    output logic [1:0]             auto_in_1_d_bits_param,
    output logic [2:0]             auto_in_1_d_bits_size,
    output logic [SRC_BITS-1:0]    auto_in_1_d_bits_source,
    output logic                   auto_in_1_d_bits_denied,
    output logic [DATA_BITS-1:0]   auto_in_1_d_bits_data,

    input  logic                   auto_out_a_ready,
    output logic                   auto_out_a_valid,
    output logic [2:0]             auto_out_a_bits_opcode,
    output logic [2:0]             auto_out_a_bits_size,
    output logic [SRC_BITS:0]      auto_out_a_bits_source,
    output logic [ADDR_BITS-1:0]   auto_out_a_bits_address,
    output logic [DATA_BITS/8-1:0] auto_out_a_bits_mask,
    output logic [DATA_BITS-1:0]   auto_out_a_bits_data,
    output logic                   auto_out_d_ready,
    input  logic                   auto_out_d_valid,
    input  logic [2:0]             auto_out_d_bits_opcode,
    input  logic [1:0]             auto_out_d_bits_param,
    input  logic [2:0]             auto_out_d_bits_size,
    input  logic [SRC_BITS:0]      auto_out_d_bits_source,
    input  logic                   auto_out_d_bits_denied,
    input  logic [DATA_BITS-1:0]   auto_out_d_bits_data
);

    typedef enum logic {A_IDLE, A_BUSY} a_state_t;

    // Beats in a message minus one; sizes up to one beat give 0.
    function automatic logic [1:0] beats_m1(input logic [2:0] size);
        int extra;
        extra = int'(size) - LOG_BEAT;
        if (extra <= 0) begin
            return 2'd0;
        end
        return 2'((1 << extra) - 1);
    endfunction

    a_state_t    a_state;
    logic        grant;
    logic        rr_ptr;
    logic [1:0]  a_cnt;
    logic [1:0]  in_valid;
    logic        sel;
    logic        a_fire;
    logic [1:0]  sel_beats_m1;
    logic        sel_multi;

    // Port selection. While BUSY the grant is frozen. This covers a locked
    // burst and also a request that was presented but not yet accepted.
    // While IDLE the round-robin pointer gets first refusal.
    always_comb begin
        in_valid = {auto_in_1_a_valid, auto_in_0_a_valid};
        sel      = rr_ptr;
        if (a_state == A_BUSY) begin
            sel = grant;
        end else if (in_valid[rr_ptr]) begin
            sel = rr_ptr;
        end else if (in_valid[~rr_ptr]) begin
            sel = ~rr_ptr;
        end
    end

    // Zero-latency A path: bits come straight from the selected port. Readies
    // are forced low during reset.
    always_comb begin
        auto_out_a_valid        = (a_state == A_BUSY) ? in_valid[grant] : |in_valid;
        auto_out_a_bits_opcode  = sel ? auto_in_1_a_bits_opcode  : auto_in_0_a_bits_opcode;
        auto_out_a_bits_size    = sel ? auto_in_1_a_bits_size    : auto_in_0_a_bits_size;
        auto_out_a_bits_source  = {sel, sel ? auto_in_1_a_bits_source : auto_in_0_a_bits_source};
        auto_out_a_bits_address = sel ? auto_in_1_a_bits_address : auto_in_0_a_bits_address;
        auto_out_a_bits_mask    = sel ? auto_in_1_a_bits_mask    : auto_in_0_a_bits_mask;
        auto_out_a_bits_data    = sel ? auto_in_1_a_bits_data    : auto_in_0_a_bits_data;
        auto_in_0_a_ready       = !reset && auto_out_a_ready && !sel;
        auto_in_1_a_ready       = !reset && auto_out_a_ready && sel;
        a_fire                  = auto_out_a_valid && auto_out_a_ready;
        sel_beats_m1            = beats_m1(auto_out_a_bits_size);
        // Only PutFullData (0) and PutPartialData (1) carry more than one beat.
        sel_multi               = (auto_out_a_bits_opcode[2:1] == 2'b00) && (sel_beats_m1 != 2'd0);
    end

    // A-channel arbiter state. A stalled request enters BUSY so the grant
    // cannot move while out valid is pending. a_cnt holds the beats still
    // owed after the current one.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_state <= A_IDLE;
            grant   <= 1'b0;
            rr_ptr  <= 1'b0;
            a_cnt   <= 2'd0;
        end else if (a_state == A_IDLE) begin
            if (a_fire) begin
                if (sel_multi) begin
                    a_state <= A_BUSY;
                    grant   <= sel;
                    a_cnt   <= sel_beats_m1 - 2'd1;
                end else begin
                    rr_ptr  <= ~sel;
                end
            end else if (auto_out_a_valid) begin
                a_state <= A_BUSY;
                grant   <= sel;
                a_cnt   <= sel_multi ? sel_beats_m1 : 2'd0;
            end
        end else if (a_fire) begin
            if (a_cnt == 2'd0) begin
                a_state <= A_IDLE;
                rr_ptr  <= ~grant;
            end else begin
                a_cnt   <= a_cnt - 2'd1;
            end
        end
    end

    logic        d_dst;
    logic        d_fire;
    logic [1:0]  d_beats_m1;
    logic        d_multi;
    logic [1:0]  d_cnt;
    logic        d_in_burst;
    logic        d_burst_dst;

    // D routing is stateless. Bits go to both ports; only the destination
    // sees valid.
    always_comb begin
        d_dst                   = auto_out_d_bits_source[SRC_BITS];
        auto_in_0_d_valid       = auto_out_d_valid && !d_dst;
        auto_in_1_d_valid       = auto_out_d_valid && d_dst;
        auto_in_0_d_bits_opcode = auto_out_d_bits_opcode;
        auto_in_1_d_bits_opcode = auto_out_d_bits_opcode;
        auto_in_0_d_bits_param  = auto_out_d_bits_param;
        auto_in_1_d_bits_param  = auto_out_d_bits_param;
        auto_in_0_d_bits_size   = auto_out_d_bits_size;
        auto_in_1_d_bits_size   = auto_out_d_bits_size;
        auto_in_0_d_bits_source = auto_out_d_bits_source[SRC_BITS-1:0];
        auto_in_1_d_bits_source = auto_out_d_bits_source[SRC_BITS-1:0];
        auto_in_0_d_bits_denied = auto_out_d_bits_denied;
        auto_in_1_d_bits_denied = auto_out_d_bits_denied;
        auto_in_0_d_bits_data   = auto_out_d_bits_data;
        auto_in_1_d_bits_data   = auto_out_d_bits_data;
        auto_out_d_ready        = d_dst ? auto_in_1_d_ready : auto_in_0_d_ready;
        d_fire                  = auto_out_d_valid && auto_out_d_ready;
        d_beats_m1              = beats_m1(auto_out_d_bits_size);
        d_multi                 = (auto_out_d_bits_opcode == 3'd1) && (d_beats_m1 != 2'd0);
    end

    // AccessAckData burst tracker. d_cnt loads beats-2 on the first beat.
    // d_in_burst marks the later beats, which tells the final beat of a
    // 2-beat burst apart from a fresh first beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            d_cnt       <= 2'd0;
            d_in_burst  <= 1'b0;
            d_burst_dst <= 1'b0;
        end else if (d_fire) begin
            if (!d_in_burst) begin
                if (d_multi) begin
                    d_cnt       <= d_beats_m1 - 2'd1;
                    d_in_burst  <= 1'b1;
                    d_burst_dst <= d_dst;
                end
            end else if (d_cnt == 2'd0) begin
                d_in_burst  <= 1'b0;
            end else begin
                d_cnt       <= d_cnt - 2'd1;
            end
        end
    end

    // Every beat of one AccessAckData burst must target the same port.
    d_burst_dst_stable: assert property (@(posedge clock) disable iff (reset)
        (d_fire && d_in_burst) |-> (d_dst == d_burst_dst));

endmodule

// File: tb/tb_tl_edge_arbiter_2to1.sv
// tb_tl_edge_arbiter_2to1
//
// Directed testbench for tl_edge_arbiter_2to1. It covers:
//   - reset behaviour;
//   - round-robin arbitration;
//   - multi-beat locking;
//   - grant stickiness under back-pressure;
//   - D routing;
//   - reset in the middle of a burst;
//   - a random run of concurrent A and D traffic.
// Inputs change just after the falling edge. Outputs are sampled 1 time unit
// later, well away from the rising edge.
module tb_tl_edge_arbiter_2to1;

    localparam int DATA_BITS = 256;
    localparam int LOG_BEAT  = 5;
    localparam int SRC_BITS  = 7;
    localparam int ADDR_BITS = 36;
    localparam int MASK_BITS = DATA_BITS / 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic                 auto_in_0_a_ready, auto_in_0_a_valid;
    logic [2:0]           auto_in_0_a_bits_opcode, auto_in_0_a_bits_size;
    logic [SRC_BITS-1:0]  auto_in_0_a_bits_source;
    logic [ADDR_BITS-1:0] auto_in_0_a_bits_address;
    logic [MASK_BITS-1:0] auto_in_0_a_bits_mask;
    logic [DATA_BITS-1:0] auto_in_0_a_bits_data;
    logic                 auto_in_0_d_ready, auto_in_0_d_valid;
    logic [2:0]           auto_in_0_d_bits_opcode, auto_in_0_d_bits_size;
    logic [1:0]           auto_in_0_d_bits_param;
    logic [SRC_BITS-1:0]  auto_in_0_d_bits_source;
    logic                 auto_in_0_d_bits_denied;
    logic [DATA_BITS-1:0] auto_in_0_d_bits_data;

    logic                 auto_in_1_a_ready, auto_in_1_a_valid;
    logic [2:0]           auto_in_1_a_bits_opcode, auto_in_1_a_bits_size;
    logic [SRC_BITS-1:0]  auto_in_1_a_bits_source;
    logic [ADDR_BITS-1:0] auto_in_1_a_bits_address;
    logic [MASK_BITS-1:0] auto_in_1_a_bits_mask;
    logic [DATA_BITS-1:0] auto_in_1_a_bits_data;
    logic                 auto_in_1_d_ready, auto_in_1_d_valid;
    logic [2:0]           auto_in_1_d_bits_opcode, auto_in_1_d_bits_size;
    logic [1:0]           auto_in_1_d_bits_param;
    logic [SRC_BITS-1:0]  auto_in_1_d_bits_source;
    logic                 auto_in_1_d_bits_denied;
    logic [DATA_BITS-1:0] auto_in_1_d_bits_data;

    logic                 auto_out_a_ready, auto_out_a_valid;
    logic [2:0]           auto_out_a_bits_opcode, auto_out_a_bits_size;
    logic [SRC_BITS:0]    auto_out_a_bits_source;
    logic [ADDR_BITS-1:0] auto_out_a_bits_address;
    logic [MASK_BITS-1:0] auto_out_a_bits_mask;
    logic [DATA_BITS-1:0] auto_out_a_bits_data;
    logic                 auto_out_d_ready, auto_out_d_valid;
    logic [2:0]           auto_out_d_bits_opcode, auto_out_d_bits_size;
    logic [1:0]           auto_out_d_bits_param;
    logic [SRC_BITS:0]    auto_out_d_bits_source;
    logic                 auto_out_d_bits_denied;
    logic [DATA_BITS-1:0] auto_out_d_bits_data;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    tl_edge_arbiter_2to1 #(
        .DATA_BITS(DATA_BITS), .LOG_BEAT(LOG_BEAT), .SRC_BITS(SRC_BITS), .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clock(clock), .reset(reset),
        .auto_in_0_a_ready(auto_in_0_a_ready), .auto_in_0_a_valid(auto_in_0_a_valid),
        .auto_in_0_a_bits_opcode(auto_in_0_a_bits_opcode), .auto_in_0_a_bits_size(auto_in_0_a_bits_size),
        .auto_in_0_a_bits_source(auto_in_0_a_bits_source), .auto_in_0_a_bits_address(auto_in_0_a_bits_address),
        .auto_in_0_a_bits_mask(auto_in_0_a_bits_mask), .auto_in_0_a_bits_data(auto_in_0_a_bits_data),
        .auto_in_0_d_ready(auto_in_0_d_ready), .auto_in_0_d_valid(auto_in_0_d_valid),
        .auto_in_0_d_bits_opcode(auto_in_0_d_bits_opcode), .auto_in_0_d_bits_param(auto_in_0_d_bits_param),
        .auto_in_0_d_bits_size(auto_in_0_d_bits_size), .auto_in_0_d_bits_source(auto_in_0_d_bits_source),
        .auto_in_0_d_bits_denied(auto_in_0_d_bits_denied), .auto_in_0_d_bits_data(auto_in_0_d_bits_data),
        .auto_in_1_a_ready(auto_in_1_a_ready), .auto_in_1_a_valid(auto_in_1_a_valid),
        .auto_in_1_a_bits_opcode(auto_in_1_a_bits_opcode), .auto_in_1_a_bits_size(auto_in_1_a_bits_size),
        .auto_in_1_a_bits_source(auto_in_1_a_bits_source), .auto_in_1_a_bits_address(auto_in_1_a_bits_address),
        .auto_in_1_a_bits_mask(auto_in_1_a_bits_mask), .auto_in_1_a_bits_data(auto_in_1_a_bits_data),
        .auto_in_1_d_ready(auto_in_1_d_ready), .auto_in_1_d_valid(auto_in_1_d_valid),
        .auto_in_1_d_bits_opcode(auto_in_1_d_bits_opcode), .auto_in_1_d_bits_param(auto_in_1_d_bits_param),
        .auto_in_1_d_bits_size(auto_in_1_d_bits_size), .auto_in_1_d_bits_source(auto_in_1_d_bits_source),
        .auto_in_1_d_bits_denied(auto_in_1_d_bits_denied), .auto_in_1_d_bits_data(auto_in_1_d_bits_data),
        .auto_out_a_ready(auto_out_a_ready), .auto_out_a_valid(auto_out_a_valid),
        .auto_out_a_bits_opcode(auto_out_a_bits_opcode), .auto_out_a_bits_size(auto_out_a_bits_size),
        .auto_out_a_bits_source(auto_out_a_bits_source), .auto_out_a_bits_address(auto_out_a_bits_address),
        .auto_out_a_bits_mask(auto_out_a_bits_mask), .auto_out_a_bits_data(auto_out_a_bits_data),
        .auto_out_d_ready(auto_out_d_ready), .auto_out_d_valid(auto_out_d_valid),
        .auto_out_d_bits_opcode(auto_out_d_bits_opcode), .auto_out_d_bits_param(auto_out_d_bits_param),
        .auto_out_d_bits_size(auto_out_d_bits_size), .auto_out_d_bits_source(auto_out_d_bits_source),
        .auto_out_d_bits_denied(auto_out_d_bits_denied), .auto_out_d_bits_data(auto_out_d_bits_data)
    );

    // Drive one input port's A channel.
    task automatic set_a(input bit port, input bit v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [SRC_BITS-1:0] src, input logic [ADDR_BITS-1:0] addr,
                         input logic [DATA_BITS-1:0] data);
        if (!port) begin
            auto_in_0_a_valid = v; auto_in_0_a_bits_opcode = op; auto_in_0_a_bits_size = sz;
            auto_in_0_a_bits_source = src; auto_in_0_a_bits_address = addr;
            auto_in_0_a_bits_mask = '1; auto_in_0_a_bits_data = data;
        end else begin
            auto_in_1_a_valid = v; auto_in_1_a_bits_opcode = op; auto_in_1_a_bits_size = sz;
            auto_in_1_a_bits_source = src; auto_in_1_a_bits_address = addr;
            auto_in_1_a_bits_mask = '1; auto_in_1_a_bits_data = data;
        end
    endtask

    // Drive the downstream D channel.
    task automatic set_d(input bit v, input logic [2:0] op, input logic [2:0] sz,
                         input logic [SRC_BITS:0] src, input logic [DATA_BITS-1:0] data);
        auto_out_d_valid = v; auto_out_d_bits_opcode = op; auto_out_d_bits_size = sz;
        auto_out_d_bits_source = src; auto_out_d_bits_data = data;
        auto_out_d_bits_param = 2'd0; auto_out_d_bits_denied = 1'b0;
    endtask

    // Readies are low while reset is held, and nothing is valid once it drops.
    task automatic test_reset();
        reset = 1'b1;
        set_a(0, 1, 3'd4, 3'd5, 7'h01, 36'h100, '0);
        set_a(1, 1, 3'd4, 3'd5, 7'h02, 36'h200, '0);
        set_d(0, 3'd0, 3'd5, 8'h00, '0);
        auto_out_a_ready = 1'b1; auto_in_0_d_ready = 1'b1; auto_in_1_d_ready = 1'b1;
        @(negedge clock); #1;
        checks++; if (auto_in_0_a_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready0: got %b expected 0", auto_in_0_a_ready); end
        checks++; if (auto_in_1_a_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready1: got %b expected 0", auto_in_1_a_ready); end
        @(negedge clock);
        reset = 1'b0;
        set_a(0, 0, 3'd4, 3'd5, 7'h01, 36'h100, '0);
        set_a(1, 0, 3'd4, 3'd5, 7'h02, 36'h200, '0);
        #1;
        checks++; if (auto_out_a_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_out_valid: got %b expected 0", auto_out_a_valid); end
        checks++; if (auto_in_0_d_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_d0_valid: got %b expected 0", auto_in_0_d_valid); end
        checks++; if (auto_in_1_d_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_d1_valid: got %b expected 0", auto_in_1_d_valid); end
    endtask

    // Both ports stream single-beat Gets: the grant alternates 0,1,0,1 at one per cycle.
    task automatic test_round_robin();
        logic                 g;
        logic [SRC_BITS:0]    exp_src;
        logic [ADDR_BITS-1:0] exp_addr;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            set_a(0, 1, 3'd4, 3'd5, 7'h11, 36'h0_1000_0000, '0);
            set_a(1, 1, 3'd4, 3'd5, 7'h22, 36'h0_2000_0000, '0);
            auto_out_a_ready = 1'b1;
            #1;
            g        = (i % 2) == 1;
            exp_src  = g ? {1'b1, 7'h22} : {1'b0, 7'h11};
            exp_addr = g ? 36'h0_2000_0000 : 36'h0_1000_0000;
            checks++; if (auto_out_a_valid !== 1'b1) begin failures++; $display("[TB] FAIL rr_valid c%0d: got %b expected 1", i, auto_out_a_valid); end
            checks++; if (auto_out_a_bits_source !== exp_src) begin failures++; $display("[TB] FAIL rr_source c%0d: got %h expected %h", i, auto_out_a_bits_source, exp_src); end
            checks++; if (auto_out_a_bits_address !== exp_addr) begin failures++; $display("[TB] FAIL rr_addr c%0d: got %h expected %h", i, auto_out_a_bits_address, exp_addr); end
            checks++; if (auto_in_0_a_ready !== !g) begin failures++; $display("[TB] FAIL rr_ready0 c%0d: got %b expected %b", i, auto_in_0_a_ready, !g); end
            checks++; if (auto_in_1_a_ready !== g) begin failures++; $display("[TB] FAIL rr_ready1 c%0d: got %b expected %b", i, auto_in_1_a_ready, g); end
        end
    endtask

    // Port0 4-beat PutFullData holds the lock; the pending port1 Get waits until cycle 5.
    task automatic test_multibeat();
        logic                 exp_port;
        logic [DATA_BITS-1:0] exp_data;
        logic [2:0]           exp_op;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            set_a(0, c < 4, 3'd0, 3'd7, 7'h33, 36'h300, DATA_BITS'(c + 1));
            set_a(1, 1, 3'd4, 3'd5, 7'h44, 36'h400, DATA_BITS'(32'hBEEF));
            auto_out_a_ready = 1'b1;
            #1;
            exp_port = (c == 4);
            exp_data = (c < 4) ? DATA_BITS'(c + 1) : DATA_BITS'(32'hBEEF);
            exp_op   = (c < 4) ? 3'd0 : 3'd4;
            checks++; if (auto_out_a_bits_source[SRC_BITS] !== exp_port) begin failures++; $display("[TB] FAIL mb_port c%0d: got %b expected %b", c, auto_out_a_bits_source[SRC_BITS], exp_port); end
            checks++; if (auto_in_0_a_ready !== !exp_port) begin failures++; $display("[TB] FAIL mb_ready0 c%0d: got %b expected %b", c, auto_in_0_a_ready, !exp_port); end
            checks++; if (auto_in_1_a_ready !== exp_port) begin failures++; $display("[TB] FAIL mb_ready1 c%0d: got %b expected %b", c, auto_in_1_a_ready, exp_port); end
            checks++; if (auto_out_a_bits_data !== exp_data) begin failures++; $display("[TB] FAIL mb_data c%0d: got %h expected %h", c, auto_out_a_bits_data[31:0], exp_data[31:0]); end
            checks++; if (auto_out_a_bits_opcode !== exp_op) begin failures++; $display("[TB] FAIL mb_opcode c%0d: got %0d expected %0d", c, auto_out_a_bits_opcode, exp_op); end
        end
        @(negedge clock);
        set_a(0, 0, 3'd4, 3'd5, 7'h00, 36'h0, '0);
        set_a(1, 0, 3'd4, 3'd5, 7'h00, 36'h0, '0);
    endtask

    // A stalled port1 request keeps the grant even though port0 has round-robin priority.
    task automatic test_stall_stickiness();
        logic              exp_port;
        logic [SRC_BITS:0] exp_src;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            set_a(1, c <= 3, 3'd4, 3'd5, 7'h55, 36'h500, '0);
            set_a(0, c >= 1, 3'd4, 3'd5, 7'h66, 36'h600, '0);
            auto_out_a_ready = (c >= 3);
            #1;
            exp_port = (c <= 3);
            exp_src  = exp_port ? {1'b1, 7'h55} : {1'b0, 7'h66};
            checks++; if (auto_out_a_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid c%0d: got %b expected 1", c, auto_out_a_valid); end
            checks++; if (auto_out_a_bits_source !== exp_src) begin failures++; $display("[TB] FAIL stall_source c%0d: got %h expected %h", c, auto_out_a_bits_source, exp_src); end
            checks++; if (auto_in_1_a_ready !== (c == 3)) begin failures++; $display("[TB] FAIL stall_ready1 c%0d: got %b expected %b", c, auto_in_1_a_ready, c == 3); end
            checks++; if (auto_in_0_a_ready !== (c == 4)) begin failures++; $display("[TB] FAIL stall_ready0 c%0d: got %b expected %b", c, auto_in_0_a_ready, c == 4); end
        end
        @(negedge clock);
        set_a(0, 0, 3'd4, 3'd5, 7'h00, 36'h0, '0);
        set_a(1, 0, 3'd4, 3'd5, 7'h00, 36'h0, '0);
    endtask

    // 2-beat AccessAckData to port1 with back-pressure, then an AccessAck to port0.
    task automatic test_d_route();
        @(negedge clock);
        set_d(1, 3'd1, 3'd6, 8'h85, DATA_BITS'(32'hD0D0));
        auto_in_1_d_ready = 1'b0; auto_in_0_d_ready = 1'b1;
        #1;
        checks++; if (auto_in_1_d_valid !== 1'b1) begin failures++; $display("[TB] FAIL d_b0_valid1: got %b expected 1", auto_in_1_d_valid); end
        checks++; if (auto_in_0_d_valid !== 1'b0) begin failures++; $display("[TB] FAIL d_b0_valid0: got %b expected 0", auto_in_0_d_valid); end
        checks++; if (auto_in_1_d_bits_source !== 7'h05) begin failures++; $display("[TB] FAIL d_b0_source: got %h expected 05", auto_in_1_d_bits_source); end
        checks++; if (auto_out_d_ready !== 1'b0) begin failures++; $display("[TB] FAIL d_backpressure: got %b expected 0", auto_out_d_ready); end
        @(negedge clock);
        auto_in_1_d_ready = 1'b1;
        #1;
        checks++; if (auto_out_d_ready !== 1'b1) begin failures++; $display("[TB] FAIL d_b0_ready: got %b expected 1", auto_out_d_ready); end
        checks++; if (auto_in_1_d_bits_data !== DATA_BITS'(32'hD0D0)) begin failures++; $display("[TB] FAIL d_b0_data: got %h expected d0d0", auto_in_1_d_bits_data[31:0]); end
        @(negedge clock);
        set_d(1, 3'd1, 3'd6, 8'h85, DATA_BITS'(32'hD1D1));
        #1;
        checks++; if (auto_in_1_d_valid !== 1'b1) begin failures++; $display("[TB] FAIL d_b1_valid1: got %b expected 1", auto_in_1_d_valid); end
        checks++; if (auto_in_0_d_valid !== 1'b0) begin failures++; $display("[TB] FAIL d_b1_valid0: got %b expected 0", auto_in_0_d_valid); end
        checks++; if (auto_in_1_d_bits_data !== DATA_BITS'(32'hD1D1)) begin failures++; $display("[TB] FAIL d_b1_data: got %h expected d1d1", auto_in_1_d_bits_data[31:0]); end
        checks++; if (auto_in_1_d_bits_opcode !== 3'd1) begin failures++; $display("[TB] FAIL d_b1_opcode: got %0d expected 1", auto_in_1_d_bits_opcode); end
        @(negedge clock);
        set_d(1, 3'd0, 3'd5, 8'h03, '0);
        auto_in_0_d_ready = 1'b0;
        #1;
        checks++; if (auto_in_0_d_valid !== 1'b1) begin failures++; $display("[TB] FAIL d_p0_valid0: got %b expected 1", auto_in_0_d_valid); end
        checks++; if (auto_in_1_d_valid !== 1'b0) begin failures++; $display("[TB] FAIL d_p0_valid1: got %b expected 0", auto_in_1_d_valid); end
        checks++; if (auto_in_0_d_bits_source !== 7'h03) begin failures++; $display("[TB] FAIL d_p0_source: got %h expected 03", auto_in_0_d_bits_source); end
        checks++; if (auto_out_d_ready !== 1'b0) begin failures++; $display("[TB] FAIL d_p0_ready_lo: got %b expected 0", auto_out_d_ready); end
        @(negedge clock);
        auto_in_0_d_ready = 1'b1;
        #1;
        checks++; if (auto_out_d_ready !== 1'b1) begin failures++; $display("[TB] FAIL d_p0_ready_hi: got %b expected 1", auto_out_d_ready); end
        @(negedge clock);
        set_d(0, 3'd0, 3'd5, 8'h00, '0);
    endtask

    // Reset after two beats of a 4-beat Put: IDLE and rr_ptr=0 on the next cycle.
    task automatic test_reset_midburst();
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            set_a(0, 1, 3'd0, 3'd7, 7'h12, 36'h700, DATA_BITS'(c));
            auto_out_a_ready = 1'b1;
            #1;
            checks++; if (auto_in_0_a_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmb_beat%0d_ready: got %b expected 1", c, auto_in_0_a_ready); end
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (auto_in_0_a_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmb_reset_ready0: got %b expected 0", auto_in_0_a_ready); end
        checks++; if (auto_in_1_a_ready !== 1'b0) begin failures++; $display("[TB] FAIL rmb_reset_ready1: got %b expected 0", auto_in_1_a_ready); end
        @(negedge clock);
        reset = 1'b0;
        set_a(0, 1, 3'd4, 3'd5, 7'h13, 36'h710, '0);
        set_a(1, 1, 3'd4, 3'd5, 7'h14, 36'h720, '0);
        #1;
        checks++; if (auto_out_a_bits_source !== {1'b0, 7'h13}) begin failures++; $display("[TB] FAIL rmb_post_source: got %h expected 13", auto_out_a_bits_source); end
        checks++; if (auto_in_0_a_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmb_post_ready0: got %b expected 1", auto_in_0_a_ready); end
        checks++; if (auto_out_a_bits_opcode !== 3'd4) begin failures++; $display("[TB] FAIL rmb_post_opcode: got %0d expected 4", auto_out_a_bits_opcode); end
        @(negedge clock);
        #1;
        checks++; if (auto_out_a_bits_source !== {1'b1, 7'h14}) begin failures++; $display("[TB] FAIL rmb_next_source: got %h expected 94", auto_out_a_bits_source); end
        checks++; if (auto_in_1_a_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmb_next_ready1: got %b expected 1", auto_in_1_a_ready); end
        @(negedge clock);
        set_a(0, 0, 3'd4, 3'd5, 7'h00, 36'h0, '0);
        set_a(1, 0, 3'd4, 3'd5, 7'h00, 36'h0, '0);
    endtask

    // Port0 A traffic and port1 D traffic run together with random valid/ready for
    // 100 cycles. IDs are checked in order and fire counts must match.
    task automatic test_concurrent();
        logic [SRC_BITS-1:0] a_id, d_id;
        bit  a_hold, d_hold, a_in_fire, a_out_fire, d_in_fire, d_out_fire;
        int  a_sent, a_recv, d_sent, d_recv;
        a_id = 7'h00; d_id = 7'h40; a_hold = 0; d_hold = 0;
        a_sent = 0; a_recv = 0; d_sent = 0; d_recv = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            set_a(0, a_hold ? 1'b1 : 1'($urandom_range(0, 1)), 3'd4, 3'd5, a_id, 36'h800, '0);
            set_a(1, 0, 3'd4, 3'd5, 7'h00, 36'h0, '0);
            auto_out_a_ready = 1'($urandom_range(0, 1));
            set_d(d_hold ? 1'b1 : 1'($urandom_range(0, 1)), 3'd0, 3'd5, {1'b1, d_id}, '0);
            auto_in_1_d_ready = 1'($urandom_range(0, 1));
            auto_in_0_d_ready = 1'($urandom_range(0, 1));
            #1;
            a_in_fire  = auto_in_0_a_valid && auto_in_0_a_ready;
            a_out_fire = auto_out_a_valid && auto_out_a_ready;
            d_out_fire = auto_out_d_valid && auto_out_d_ready;
            d_in_fire  = auto_in_1_d_valid && auto_in_1_d_ready;
            checks++; if (a_in_fire !== a_out_fire) begin failures++; $display("[TB] FAIL cc_a_fire c%0d: out %b expected %b", c, a_out_fire, a_in_fire); end
            checks++; if (d_in_fire !== d_out_fire) begin failures++; $display("[TB] FAIL cc_d_fire c%0d: port1 %b expected %b", c, d_in_fire, d_out_fire); end
            checks++; if (auto_in_0_d_valid !== 1'b0) begin failures++; $display("[TB] FAIL cc_d0_valid c%0d: got %b expected 0", c, auto_in_0_d_valid); end
            if (a_out_fire) begin
                a_recv++;
                checks++; if (auto_out_a_bits_source !== {1'b0, a_id}) begin failures++; $display("[TB] FAIL cc_a_source c%0d: got %h expected %h", c, auto_out_a_bits_source, {1'b0, a_id}); end
            end
            if (d_in_fire) begin
                d_recv++;
                checks++; if (auto_in_1_d_bits_source !== d_id) begin failures++; $display("[TB] FAIL cc_d_source c%0d: got %h expected %h", c, auto_in_1_d_bits_source, d_id); end
            end
            if (auto_in_0_a_valid && auto_out_a_ready) begin
                a_sent++; a_id = a_id + 7'd1; a_hold = 0;
            end else begin
                a_hold = auto_in_0_a_valid;
            end
            if (auto_out_d_valid && auto_in_1_d_ready) begin
                d_sent++; d_id = d_id + 7'd1; d_hold = 0;
            end else begin
                d_hold = auto_out_d_valid;
            end
        end
        checks++; if (a_recv !== a_sent) begin failures++; $display("[TB] FAIL cc_a_count: got %0d expected %0d", a_recv, a_sent); end
        checks++; if (d_recv !== d_sent) begin failures++; $display("[TB] FAIL cc_d_count: got %0d expected %0d", d_recv, d_sent); end
        checks++; if (a_sent == 0 || d_sent == 0) begin failures++; $display("[TB] FAIL cc_activity: got a=%0d d=%0d expected both nonzero", a_sent, d_sent); end
        @(negedge clock);
        set_a(0, 0, 3'd4, 3'd5, 7'h00, 36'h0, '0);
        set_d(0, 3'd0, 3'd5, 8'h00, '0);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_multibeat();
        test_stall_stickiness();
        test_d_route();
        test_reset_midburst();
        test_concurrent();
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
